alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared ALU. It grants one port per cycle and feeds a single registered result stage.
// The optional performance counters are built only when ALU_ARB_PERF_EN is defined; otherwise perf_* are tied to 0.

package my_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  } alu_ops_t;
endpackage

module alu_arbiter
  import my_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  alu_ops_t    req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  alu_ops_t    req1_ctrl,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output alu_ops_t    alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_branch,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_branch,
  output logic        rsp_id,
  output logic [31:0] perf_gnt0,
  output logic [31:0] perf_gnt1,
  output logic [31:0] perf_stall
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        rsp_valid_reg;
  logic [31:0] rsp_result_reg;
  logic        rsp_branch_reg;
  logic        rsp_id_reg;
  logic [3:0]  starve_reg, starve_next;
  logic [31:0] op1_reg, op2_reg;
  alu_ops_t    ctrl_reg;

  logic can_accept, promoted, sel1, grant0, grant1, grant_any;

  assign can_accept = !rsp_valid_reg || rsp_ready;
  assign promoted   = (starve_reg == LIMIT);
  // Port 1 is offered the slot when promoted or when port 0 has nothing to send.
  assign sel1       = req1_valid && (promoted || !req0_valid);
  assign req0_ready = rst_n && can_accept && !sel1;
  assign req1_ready = rst_n && can_accept && sel1;
  assign grant0     = req0_ready && req0_valid;
  assign grant1     = req1_ready && req1_valid;
  assign grant_any  = grant0 || grant1;

  // The ALU sees the winning port's operation; otherwise the last granted one is held.
  always_comb begin
    alu_op1  = op1_reg;
    alu_op2  = op2_reg;
    alu_ctrl = ctrl_reg;
    if (grant1) begin
      alu_op1  = req1_op1;
      alu_op2  = req1_op2;
      alu_ctrl = req1_ctrl;
    end else if (grant0) begin
      alu_op1  = req0_op1;
      alu_op2  = req0_op2;
      alu_ctrl = req0_ctrl;
    end
  end

  always_comb begin
    starve_next = starve_reg;
    if (grant1 || !req1_valid) begin
      starve_next = '0;
    end else if (grant0 && (starve_reg != LIMIT)) begin
      starve_next = starve_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_branch_reg <= 1'b0;
      rsp_id_reg     <= 1'b0;
      starve_reg     <= '0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      ctrl_reg       <= ALU_ADD;
    end else begin
      starve_reg <= starve_next;
      if (grant_any) begin
        rsp_valid_reg  <= 1'b1;
        rsp_result_reg <= alu_result;
        rsp_branch_reg <= alu_branch;
        rsp_id_reg     <= grant1;
        op1_reg        <= alu_op1;
        op2_reg        <= alu_op2;
        ctrl_reg       <= alu_ctrl;
      end else if (can_accept) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_branch = rsp_branch_reg;
  assign rsp_id     = rsp_id_reg;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] gnt0_reg, gnt1_reg, stall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_reg  <= '0;
      gnt1_reg  <= '0;
      stall_reg <= '0;
    end else begin
      if (grant0) gnt0_reg <= gnt0_reg + 32'd1;
      if (grant1) gnt1_reg <= gnt1_reg + 32'd1;
      if ((req0_valid || req1_valid) && !grant_any) stall_reg <= stall_reg + 32'd1;
    end
  end

  assign perf_gnt0  = gnt0_reg;
  assign perf_gnt1  = gnt1_reg;
  assign perf_stall = stall_reg;
`else
  assign perf_gnt0  = '0;
  assign perf_gnt1  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// A behavioural ALU closes the loop on alu_* so results can be predicted from each port's own operands.

module tb_alu_arbiter;
  import my_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, rr;
  logic [31:0] a0, b0, a1, b1;
  alu_ops_t    c0, c1;
  logic        req0_ready, req1_ready;
  logic [31:0] alu_op1, alu_op2, alu_result;
  alu_ops_t    alu_ctrl;
  logic        alu_branch;
  logic        rsp_valid, rsp_branch, rsp_id;
  logic [31:0] rsp_result;
  logic [31:0] perf_gnt0, perf_gnt1, perf_stall;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  bit          m_valid;
  logic [31:0] m_result;
  bit          m_branch;
  bit          m_id;
  int          m_losses;
  logic [31:0] m_op1;
  alu_ops_t    m_ctrl;
  int          m_g0, m_g1, m_stall;
  int          seq31[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int          stall_before;

  always #5 clk = ~clk;

  alu_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_op1(a0), .req0_op2(b0), .req0_ctrl(c0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_op1(a1), .req1_op2(b1), .req1_ctrl(c1),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_branch(alu_branch),
    .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_result(rsp_result),
    .rsp_branch(rsp_branch), .rsp_id(rsp_id),
    .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_stall(perf_stall)
  );

  function automatic logic [31:0] ref_res(alu_ops_t c, logic [31:0] a, logic [31:0] b);
    case (c)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic ref_br(alu_ops_t c, logic [31:0] a, logic [31:0] b);
    case (c)
      ALU_BEQ:  return a == b;
      ALU_BNE:  return a != b;
      ALU_BLT:  return $signed(a) < $signed(b);
      ALU_BGE:  return $signed(a) >= $signed(b);
      ALU_BLTU: return a < b;
      ALU_BGEU: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction

  assign alu_result = ref_res(alu_ctrl, alu_op1, alu_op2);
  assign alu_branch = ref_br(alu_ctrl, alu_op1, alu_op2);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_result = '0; m_branch = 0; m_id = 0; m_losses = 0;
    m_op1 = '0; m_ctrl = ALU_ADD; m_g0 = 0; m_g1 = 0; m_stall = 0;
  endtask

  task automatic set_in(input logic nv0, input alu_ops_t nc0, input logic [31:0] na0, input logic [31:0] nb0,
                        input logic nv1, input alu_ops_t nc1, input logic [31:0] na1, input logic [31:0] nb1,
                        input logic nrr);
    v0 = nv0; c0 = nc0; a0 = na0; b0 = nb0;
    v1 = nv1; c1 = nc1; a1 = na1; b1 = nb1;
    rr = nrr;
  endtask

  // Compare the DUT against the model for the current cycle, then advance the model across the next edge.
  task automatic eval();
    bit accept;
    int win;
    logic [31:0] exp_op1;
    alu_ops_t exp_ctrl;
    accept = !m_valid || rr;
    win = -1;
    if (accept) begin
      if (v1 && (m_losses >= int'(LIMIT) || !v0)) win = 1;
      else if (v0) win = 0;
    end
    exp_op1  = (win == 1) ? a1 : (win == 0) ? a0 : m_op1;
    exp_ctrl = (win == 1) ? c1 : (win == 0) ? c0 : m_ctrl;

    check_val("ready1", 32'(req1_ready), 32'(win == 1));
    check_val("ready0", 32'(req0_ready), 32'(accept && win != 1));
    check_val("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check_val("rsp_result", rsp_result, m_result);
    check_val("rsp_branch", 32'(rsp_branch), 32'(m_branch));
    check_val("rsp_id", 32'(rsp_id), 32'(m_id));
    check_val("alu_op1", alu_op1, exp_op1);
    check_val("alu_ctrl", 32'(alu_ctrl), 32'(exp_ctrl));
`ifdef ALU_ARB_PERF_EN
    check_val("perf_gnt0", perf_gnt0, 32'(m_g0));
    check_val("perf_gnt1", perf_gnt1, 32'(m_g1));
    check_val("perf_stall", perf_stall, 32'(m_stall));
`else
    check_val("perf_gnt0", perf_gnt0, 32'd0);
    check_val("perf_gnt1", perf_gnt1, 32'd0);
    check_val("perf_stall", perf_stall, 32'd0);
`endif

    if (win >= 0) begin
      m_valid  = 1;
      m_id     = (win == 1);
      m_result = (win == 1) ? ref_res(c1, a1, b1) : ref_res(c0, a0, b0);
      m_branch = (win == 1) ? ref_br(c1, a1, b1) : ref_br(c0, a0, b0);
      m_op1    = exp_op1;
      m_ctrl   = exp_ctrl;
      $display("txn port=%0d ctrl=%s result=%h branch=%0d", win, exp_ctrl.name(), m_result, m_branch);
    end else if (accept) begin
      m_valid = 0;
    end
    if (win == 1 || !v1) m_losses = 0;
    else if (win == 0 && m_losses < int'(LIMIT)) m_losses++;
    if (win == 0) m_g0++;
    if (win == 1) m_g1++;
    if ((v0 || v1) && win < 0) m_stall++;
  endtask

  task automatic cycle();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, ALU_ADD, 0, 0, 0, ALU_ADD, 0, 0, 1);
    model_reset();
    #1;
    check_val("reset_valid", 32'(rsp_valid), 32'd0);
    check_val("reset_ready0", 32'(req0_ready), 32'd0);
    check_val("reset_ready1", 32'(req1_ready), 32'd0);
    check_val("reset_result", rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD on port 0
    set_in(1, ALU_ADD, 5, 7, 0, ALU_ADD, 0, 0, 1);
    cycle();
    check_val("add_valid", 32'(rsp_valid), 32'd1);
    check_val("add_result", rsp_result, 32'd12);
    check_val("add_id", 32'(rsp_id), 32'd0);

    // Both ports saturated: port 1 wins once every LIMIT+1 grants
    for (int i = 0; i < 10; i++) begin
      set_in(1, ALU_ADD, 32'(i), 1, 1, ALU_OR, 32'(i), 2, 1);
      cycle();
      check_val($sformatf("starve_seq%0d", i), 32'(rsp_id), 32'(seq31[i]));
    end

    // SUB on port 1 held under back-pressure
    set_in(0, ALU_ADD, 0, 0, 0, ALU_ADD, 0, 0, 1);
    cycle();
    set_in(0, ALU_ADD, 0, 0, 1, ALU_SUB, 3, 5, 1);
    cycle();
    check_val("sub_result", rsp_result, 32'hFFFF_FFFE);
    stall_before = m_stall;
    for (int i = 0; i < 3; i++) begin
      set_in(0, ALU_ADD, 0, 0, 1, ALU_SUB, 10, 1, 0);
      #1;
      check_val("hold_ready0", 32'(req0_ready), 32'd0);
      check_val("hold_ready1", 32'(req1_ready), 32'd0);
      cycle();
      check_val("hold_result", rsp_result, 32'hFFFF_FFFE);
      check_val("hold_id", 32'(rsp_id), 32'd1);
    end
`ifdef ALU_ARB_PERF_EN
    check_val("stall_count", perf_stall, 32'(stall_before + 3));
`endif
    set_in(0, ALU_ADD, 0, 0, 1, ALU_SUB, 10, 1, 1);
    cycle();
    check_val("drain_new_result", rsp_result, 32'd9);

    // Branch compare: result stays 0, branch follows the ALU
    set_in(1, ALU_BEQ, 9, 9, 0, ALU_ADD, 0, 0, 1);
    cycle();
    check_val("beq_taken", 32'(rsp_branch), 32'd1);
    check_val("beq_result", rsp_result, 32'd0);
    set_in(1, ALU_BEQ, 9, 8, 0, ALU_ADD, 0, 0, 1);
    cycle();
    check_val("beq_not_taken", 32'(rsp_branch), 32'd0);
    set_in(0, ALU_ADD, 0, 0, 0, ALU_ADD, 0, 0, 1);
    cycle();
    check_val("drain_idle", 32'(rsp_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom % 4) != 0, alu_ops_t'(4'($urandom_range(0, 15))), $urandom, $urandom_range(0, 40),
             ($urandom % 4) != 0, alu_ops_t'(4'($urandom_range(0, 15))), $urandom_range(0, 40), $urandom_range(0, 40),
             ($urandom % 4) != 0);
      cycle();
    end

    // Reset pulse while a result is held
    set_in(1, ALU_ADD, 1, 2, 0, ALU_ADD, 0, 0, 0);
    cycle();
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_mid_result", rsp_result, 32'd0);
    check_val("rst_mid_ready0", 32'(req0_ready), 32'd0);
    check_val("rst_mid_ready1", 32'(req1_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, ALU_ADD, 20, 22, 0, ALU_ADD, 0, 0, 0);
    #1;
    eval();
    @(posedge clk);
    #1;
    check_val("post_rst_valid", 32'(rsp_valid), 32'd1);
    check_val("post_rst_result", rsp_result, 32'd42);
    for (int i = 0; i < 40; i++) begin
      set_in(($urandom % 2) != 0, alu_ops_t'(4'($urandom_range(0, 15))), $urandom_range(0, 20), $urandom_range(0, 20),
             ($urandom % 2) != 0, alu_ops_t'(4'($urandom_range(0, 15))), $urandom_range(0, 20), $urandom_range(0, 20),
             ($urandom % 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
